// File: rtl/codec_cfg_ctrl.sv
// Codec configuration controller: replays an 8-entry init table through a
// two-cycle serial-writer handshake, then serves runtime register writes.
module codec_cfg_ctrl #(
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        user_req,
    input  logic [14:0] user_data,
    output logic        user_ack,
    output logic        spi_req,
    output logic [14:0] spi_data,
    input  logic        spi_done,
    output logic        init_done,
    output logic        busy,
    output logic        err
);

    localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [7:0]      TO_LIM   = (TIMEOUT > 255) ? 8'hFF : 8'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, RUN} state_t;

    state_t        r_state;
    logic [2:0]    r_idx;
    logic [1:0]    r_req_cnt;
    logic [7:0]    r_tcnt;
    logic [GW-1:0] r_gcnt;
    logic          r_user;
    logic          r_req;
    logic [14:0]   r_data;
    logic          r_ack;
    logic          r_init_done;
    logic          r_busy;
    logic          r_err;

    function automatic logic [14:0] f_table(input logic [2:0] idx);
        case (idx)
            3'd0:    f_table = 15'h0F00;
            3'd1:    f_table = 15'h0600;
            3'd2:    f_table = 15'h0017;
            3'd3:    f_table = 15'h0279;
            3'd4:    f_table = 15'h0412;
            3'd5:    f_table = 15'h0500;
            3'd6:    f_table = 15'h0702;
            default: f_table = 15'h0901;
        endcase
    endfunction

    function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
        f_sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_idx       <= 3'd0;
            r_req_cnt   <= 2'd0;
            r_tcnt      <= 8'd0;
            r_gcnt      <= '0;
            r_user      <= 1'b0;
            r_req       <= 1'b0;
            r_data      <= 15'd0;
            r_ack       <= 1'b0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx     <= 3'd0;
                        r_data    <= f_table(3'd0);
                        r_user    <= 1'b0;
                        r_err     <= 1'b0;
                        r_req_cnt <= 2'd0;
                        r_tcnt    <= 8'd0;
                        r_busy    <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                // Data is already on spi_data for one cycle before spi_req rises;
                // the timeout window opens on the first spi_req cycle.
                REQ: begin
                    case (r_req_cnt)
                        2'd0: begin
                            r_req     <= 1'b1;
                            r_req_cnt <= 2'd1;
                            r_tcnt    <= 8'd1;
                        end
                        2'd1: begin
                            r_req_cnt <= 2'd2;
                            r_tcnt    <= f_sat_inc(r_tcnt);
                        end
                        default: begin
                            r_req     <= 1'b0;
                            r_req_cnt <= 2'd0;
                            r_tcnt    <= f_sat_inc(r_tcnt);
                            r_state   <= WAIT;
                        end
                    endcase
                end
                WAIT: begin
                    if (spi_done) begin
                        r_gcnt  <= '0;
                        r_ack   <= r_user;
                        r_state <= GAP;
                    end else if (r_tcnt >= TO_LIM) begin
                        r_err       <= 1'b1;
                        r_init_done <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_tcnt <= f_sat_inc(r_tcnt);
                    end
                end
                GAP: begin
                    if (r_gcnt == GAP_LAST) begin
                        if (r_user) begin
                            r_busy  <= 1'b0;
                            r_state <= RUN;
                        end else if (r_idx == 3'd7) begin
                            r_init_done <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= RUN;
                        end else begin
                            r_idx     <= r_idx + 3'd1;
                            r_data    <= f_table(r_idx + 3'd1);
                            r_req_cnt <= 2'd0;
                            r_tcnt    <= 8'd0;
                            r_state   <= REQ;
                        end
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                // start has priority; a held user_req stays pending until the
                // re-run init completes.
                RUN: begin
                    if (start) begin
                        r_idx       <= 3'd0;
                        r_data      <= f_table(3'd0);
                        r_user      <= 1'b0;
                        r_init_done <= 1'b0;
                        r_req_cnt   <= 2'd0;
                        r_tcnt      <= 8'd0;
                        r_busy      <= 1'b1;
                        r_state     <= REQ;
                    end else if (user_req) begin
                        r_data    <= user_data;
                        r_user    <= 1'b1;
                        r_req_cnt <= 2'd0;
                        r_tcnt    <= 8'd0;
                        r_busy    <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign spi_req   = r_req;
    assign spi_data  = r_data;
    assign user_ack  = r_ack;
    assign init_done = r_init_done;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
